// File: rtl/frame_stream_decoder.sv
// Decodes the CPU graphics word stream (sync, width, height, pixels) into
// framebuffer writes; every output is registered one cycle after acceptance.
module frame_stream_decoder #(
  parameter logic [31:0] SYNC_WORD = 32'hF00D_F00D,
  parameter int unsigned MAX_W     = 640,
  parameter int unsigned MAX_H     = 480,
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned PIX_W     = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_out,
  input  logic              out_valid,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [PIX_W-1:0]  fb_data,
  output logic [15:0]       frame_w,
  output logic [15:0]       frame_h,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       frame_count
);

  typedef enum logic [1:0] {IDLE, GET_W, GET_H, PIXELS} state_t;

  localparam logic [15:0]       MAX_W16 = 16'(MAX_W);
  localparam logic [15:0]       MAX_H16 = 16'(MAX_H);
  localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(MAX_W);

  state_t            state, state_next;
  logic [15:0]       x, y;
  logic [ADDR_W-1:0] row_base;

  logic is_sync, w_bad, h_bad, last_col, last_row;

  assign is_sync  = (cpu_out == SYNC_WORD);
  assign w_bad    = (cpu_out[15:0] == 16'd0) || (cpu_out[15:0] > MAX_W16);
  assign h_bad    = (cpu_out[15:0] == 16'd0) || (cpu_out[15:0] > MAX_H16);
  assign last_col = (x == frame_w - 16'd1);
  assign last_row = (y == frame_h - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (out_valid) begin
      unique case (state)
        IDLE:    if (is_sync) state_next = GET_W;
        GET_W:   state_next = w_bad ? IDLE : GET_H;
        GET_H:   state_next = h_bad ? IDLE : PIXELS;
        PIXELS: begin
          if (is_sync)                  state_next = GET_W;
          else if (last_col && last_row) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // busy derives from the state register, so it falls on the same cycle
  // that the registered frame_done/frame_err pulse appears.
  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_data     <= '0;
      frame_w     <= '0;
      frame_h     <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
      x           <= '0;
      y           <= '0;
      row_base    <= '0;
    end else begin
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (out_valid) begin
        unique case (state)
          GET_W: begin
            frame_w <= cpu_out[15:0];
            if (w_bad) frame_err <= 1'b1;
          end
          GET_H: begin
            frame_h  <= cpu_out[15:0];
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            if (h_bad) frame_err <= 1'b1;
          end
          PIXELS: begin
            if (is_sync) begin
              frame_err <= 1'b1;
            end else begin
              fb_we   <= 1'b1;
              fb_addr <= row_base + ADDR_W'(x);
              fb_data <= cpu_out[PIX_W-1:0];
              if (last_col) begin
                x        <= '0;
                y        <= y + 16'd1;
                row_base <= row_base + STRIDE;
                if (last_row) begin
                  frame_done  <= 1'b1;
                  frame_count <= frame_count + 16'd1;
                end
              end else begin
                x <= x + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_stream_decoder.sv
// Scoreboard bench for frame_stream_decoder: expected write/error events are
// queued as words are driven and matched against DUT pulses on the falling edge.
module tb_frame_stream_decoder;

  localparam logic [31:0] SYNC = 32'hF00D_F00D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_out = '0;
  logic        out_valid = 1'b0;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [23:0] fb_data;
  logic [15:0] frame_w, frame_h, frame_count;
  logic        busy, frame_done, frame_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          err;
    logic [18:0] addr;
    logic [23:0] data;
    bit          done;
  } ev_t;
  ev_t q[$];

  frame_stream_decoder #(
    .SYNC_WORD(SYNC), .MAX_W(640), .MAX_H(480), .ADDR_W(19), .PIX_W(24)
  ) dut (
    .clk(clk), .rst(rst), .cpu_out(cpu_out), .out_valid(out_valid),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .frame_w(frame_w), .frame_h(frame_h), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (fb_we || frame_err || frame_done) begin
      ev_t e;
      bit  mism;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: we=%0b err=%0b done=%0b addr=%0d data=%h, required no event",
                 fb_we, frame_err, frame_done, fb_addr, fb_data);
      end else begin
        e = q.pop_front();
        if (e.err)
          mism = ({frame_err, fb_we, frame_done} !== 3'b100);
        else
          mism = ({frame_err, fb_we, frame_done, fb_addr, fb_data} !==
                  {1'b0, 1'b1, e.done, e.addr, e.data});
        if (mism) begin
          bad++;
          $display("FAIL event: got err=%0b we=%0b done=%0b addr=%0d data=%h, required err=%0b done=%0b addr=%0d data=%h",
                   frame_err, fb_we, frame_done, fb_addr, fb_data, e.err, e.done, e.addr, e.data);
        end
      end
    end
  end

  task automatic send(input logic [31:0] w);
    cpu_out   = w;
    out_valid = 1'b1;
    @(posedge clk); #1;
    out_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    out_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_err();
    ev_t e;
    e.err = 1'b1; e.addr = '0; e.data = '0; e.done = 1'b0;
    q.push_back(e);
  endtask

  task automatic send_pix(input int unsigned x, input int unsigned y,
                          input logic [31:0] w, input bit last);
    ev_t e;
    e.err  = 1'b0;
    e.addr = 19'(y * 640 + x);
    e.data = w[23:0];
    e.done = last;
    q.push_back(e);
    send(w);
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    while (q.size() != 0 && n < 10) begin @(posedge clk); #1; n++; end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: pending=%0d required=0", name, q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; out_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cpu_out = '0;
    do_reset();
    total++;
    if ({fb_we, fb_addr, fb_data, frame_w, frame_h, busy, frame_done, frame_err, frame_count} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: we=%0b addr=%0d data=%h w=%0d h=%0d busy=%0b cnt=%0d, required all 0",
               fb_we, fb_addr, fb_data, frame_w, frame_h, busy, frame_count);
    end
    cpu_out = SYNC;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      total++;
      if ({fb_we, busy, frame_done, frame_err, frame_count, frame_w} !== '0) begin
        bad++;
        $display("FAIL invalid_ignored: cycle %0d busy=%0b we=%0b, required all 0", i, busy, fb_we);
      end
    end
  endtask

  task automatic test_basic();
    send(SYNC); send(32'd2); send(32'd2);
    send_pix(0, 0, 32'h0000_00A1, 1'b0);
    send_pix(1, 0, 32'h0000_00B2, 1'b0);
    send_pix(0, 1, 32'h0000_00C3, 1'b0);
    send_pix(1, 1, 32'h0000_00D4, 1'b1);
    total++;
    if (busy !== 1'b0 || frame_done !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy_drop: busy=%0b done=%0b required busy=0 done=1", busy, frame_done);
    end
    drain("basic");
    total++;
    if (frame_count !== 16'd1 || frame_w !== 16'd2 || frame_h !== 16'd2) begin
      bad++;
      $display("FAIL basic_count: cnt=%0d w=%0d h=%0d required 1 2 2", frame_count, frame_w, frame_h);
    end
  endtask

  task automatic test_bad_header();
    send(SYNC); push_err(); send(32'd0);
    send(SYNC); push_err(); send(32'd641);
    send(SYNC); send(32'd4); push_err(); send(32'd481);
    total++;
    if (busy !== 1'b0 || frame_w !== 16'd4 || frame_h !== 16'd481) begin
      bad++;
      $display("FAIL bad_header_state: busy=%0b w=%0d h=%0d required 0 4 481", busy, frame_w, frame_h);
    end
    // Maximum legal dimensions, then resync, then SYNC as the width word.
    send(SYNC); send(32'hFFFF_0280); send(32'd480);
    total++;
    if (busy !== 1'b1 || frame_w !== 16'd640) begin
      bad++;
      $display("FAIL max_header: busy=%0b w=%0d required 1 640", busy, frame_w);
    end
    push_err(); send(SYNC);
    push_err(); send(SYNC);
    drain("bad_header");
    total++;
    if (busy !== 1'b0 || frame_count !== 16'd1) begin
      bad++;
      $display("FAIL bad_header_count: busy=%0b cnt=%0d required 0 1", busy, frame_count);
    end
  endtask

  task automatic test_resync();
    do_reset();
    send(SYNC); send(32'd3); send(32'd2);
    send_pix(0, 0, 32'h0011_2233, 1'b0);
    send_pix(1, 0, 32'h0044_5566, 1'b0);
    push_err(); send(SYNC);
    total++;
    if (busy !== 1'b1 || frame_err !== 1'b1 || fb_we !== 1'b0) begin
      bad++;
      $display("FAIL resync_pulse: busy=%0b err=%0b we=%0b required 1 1 0", busy, frame_err, fb_we);
    end
    send(32'd1); send(32'd1);
    send_pix(0, 0, 32'h0077_8899, 1'b1);
    drain("resync");
    total++;
    if (frame_count !== 16'd1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL resync_count: cnt=%0d busy=%0b required 1 0", frame_count, busy);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    send(32'h1234_5678); idle(2); send(32'hF00D_F00C); idle(1); send(32'd7);
    send(SYNC); idle(3); send(32'd1); idle(3); send(32'd1); idle(3);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL gaps_busy: busy=%0b required 1", busy);
    end
    send_pix(0, 0, 32'hAB12_3456, 1'b1);
    total++;
    if (fb_data !== 24'h123456 || fb_addr !== 19'd0 || frame_done !== 1'b1) begin
      bad++;
      $display("FAIL gaps_write: addr=%0d data=%h done=%0b required 0 123456 1", fb_addr, fb_data, frame_done);
    end
    idle(3);
    drain("gaps");
    total++;
    if (frame_count !== 16'd1 || fb_data !== 24'h123456) begin
      bad++;
      $display("FAIL gaps_hold: cnt=%0d data=%h required 1 123456", frame_count, fb_data);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send(SYNC); send(32'd2); send(32'd2);
    send_pix(0, 0, 32'h0000_0001, 1'b0);
    send_pix(1, 0, 32'h0000_0002, 1'b0);
    send_pix(0, 1, 32'h0000_0003, 1'b0);
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({fb_we, fb_addr, fb_data, frame_w, frame_h, busy, frame_done, frame_err, frame_count} !== '0) begin
      bad++;
      $display("FAIL midframe_reset: we=%0b addr=%0d busy=%0b w=%0d, required all 0", fb_we, fb_addr, busy, frame_w);
    end
    rst = 1'b0;
    send(32'h0000_0004); // stray word in IDLE after reset must be dropped
    send(SYNC); send(32'd2); send(32'd2);
    send_pix(0, 0, 32'h00AA_0000, 1'b0);
    send_pix(1, 0, 32'h00BB_0000, 1'b0);
    send_pix(0, 1, 32'h00CC_0000, 1'b0);
    send_pix(1, 1, 32'h00DD_0000, 1'b1);
    drain("midframe");
    total++;
    if (frame_count !== 16'd1) begin
      bad++;
      $display("FAIL midframe_count: cnt=%0d required 1", frame_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    do_reset();
    send(SYNC); send(32'd3); send(32'd2);
    for (int unsigned y = 0; y < 2; y++)
      for (int unsigned x = 0; x < 3; x++) begin
        w = {8'h00, 24'($urandom)};
        send_pix(x, y, w, (x == 2) && (y == 1));
      end
    send(SYNC); send(32'd1); send(32'd3);
    for (int unsigned y = 0; y < 3; y++) begin
      w = {8'h5A, 24'($urandom)};
      send_pix(0, y, w, y == 2);
    end
    drain("b2b");
    total++;
    if (frame_count !== 16'd2 || frame_w !== 16'd1 || frame_h !== 16'd3 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_count: cnt=%0d w=%0d h=%0d busy=%0b required 2 1 3 0",
               frame_count, frame_w, frame_h, busy);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_bad_header();
    test_resync();
    test_gaps();
    test_reset_midframe();
    test_back_to_back();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
